// File: rtl/softermax_pkg.sv
// rtl/softermax_pkg.sv - shared defaults and drain FSM encoding for the softermax drain
package softermax_pkg;

    localparam int DEF_ROW_WIDTH = 8;
    localparam int DEF_PROB_W    = 33;
    localparam int DEF_OUT_W     = 16;
    localparam int ADDR_W        = $clog2(DEF_ROW_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

endpackage

// File: rtl/drain_fifo.sv
// rtl/drain_fifo.sv - synchronous FIFO with occupancy count and simultaneous push/pop
module drain_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/softermax_drain.sv
// rtl/softermax_drain.sv - drains one softermax row per done edge into a narrowed stream (option: SOFTERMAX_DRAIN_SAT_EN)
module softermax_drain
    import softermax_pkg::*;
#(
    parameter int ROW_WIDTH  = DEF_ROW_WIDTH,
    parameter int PROB_W     = DEF_PROB_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sm_done,
    output logic [$clog2(ROW_WIDTH)-1:0] sm_read_addr,
    input  logic [PROB_W-1:0]            sm_prob,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic [$clog2(ROW_WIDTH)-1:0] out_idx,
    output logic                         out_last,
    output logic                         busy,
    output logic                         row_release,
    output logic                         overrun,
    input  logic                         clear_overrun
`ifdef SOFTERMAX_DRAIN_SAT_EN
    ,
    output logic                         sat_seen
`endif
);

    localparam int IDX_W = $clog2(ROW_WIDTH);
    localparam int ENT_W = OUT_W + IDX_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_WIDTH - 1);

    drain_state_e     state_q, state_d;
    logic             sm_done_q;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0] rd_addr_q, rd_addr_d;
    logic             inflight_q, inflight_d;
    logic             row_release_q, row_release_d;
    logic             overrun_q, overrun_d;

    logic             start;
    logic             credit_ok;
    logic             pop;
    logic [CNT_W:0]   used;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [ENT_W-1:0] fifo_wdata;
    logic [ENT_W-1:0] fifo_rdata;
    logic [OUT_W-1:0] narrowed;

    assign start = sm_done & ~sm_done_q;

    // A read occupies one FIFO credit from issue until its word lands, so
    // the FIFO can never be asked to take a word it has no room for.
    assign used      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok = (used < (CNT_W + 1)'(FIFO_DEPTH));

`ifdef SOFTERMAX_DRAIN_SAT_EN
    logic sat_hit;
    logic sat_seen_q, sat_seen_d;

    // Any surviving bit above the output window means the value does not fit.
    assign sat_hit  = |(sm_prob >> (SHIFT + OUT_W));
    assign narrowed = sat_hit ? '1 : OUT_W'(sm_prob >> SHIFT);
`else
    assign narrowed = OUT_W'(sm_prob >> SHIFT);
`endif

    // The registered read address is the index of the word on sm_prob this cycle.
    assign fifo_wdata = {(rd_addr_q == LAST_IDX), rd_addr_q, narrowed};

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign {out_last, out_idx, out_data} = fifo_rdata;

    drain_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Drain FSM: issue reads under credit, then wait for the last word to leave.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rd_addr_d     = rd_addr_q;
        inflight_d    = 1'b0;
        row_release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    addr_d  = '0;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    rd_addr_d  = addr_q;
                    addr_d     = addr_q + IDX_W'(1);
                    inflight_d = 1'b1;
                    if (addr_q == LAST_IDX) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!inflight_q && (fifo_count == CNT_W'(1)) && pop && out_last) begin
                    state_d       = IDLE;
                    row_release_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky flags: a new event in the same cycle as a clear wins.
    always_comb begin
        overrun_d = overrun_q;
        if (start && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end
`ifdef SOFTERMAX_DRAIN_SAT_EN
        sat_seen_d = sat_seen_q;
        if (inflight_q && sat_hit) begin
            sat_seen_d = 1'b1;
        end else if (clear_overrun) begin
            sat_seen_d = 1'b0;
        end
`endif
    end

    // Control registers; reset aborts any row without a release pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sm_done_q     <= 1'b0;
            addr_q        <= '0;
            rd_addr_q     <= '0;
            inflight_q    <= 1'b0;
            row_release_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sm_done_q     <= sm_done;
            addr_q        <= addr_d;
            rd_addr_q     <= rd_addr_d;
            inflight_q    <= inflight_d;
            row_release_q <= row_release_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef SOFTERMAX_DRAIN_SAT_EN
    // Saturation observed flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_seen_q <= 1'b0;
        end else begin
            sat_seen_q <= sat_seen_d;
        end
    end

    assign sat_seen = sat_seen_q;
`endif

    assign sm_read_addr = rd_addr_q;
    assign busy         = (state_q != IDLE);
    assign row_release  = row_release_q;
    assign overrun      = overrun_q;

endmodule
